pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit for the 5-stage RV32I core, sitting beside the ID stage. It takes the decoded opcode and source registers of the instruction in ID, the EX-stage destination and load flag, the EX branch-redirect flag and the data-memory busy flag. From these it sequences the PC, IF/ID, ID/EX and downstream pipeline registers. It inserts load-use bubbles and wrong-path flushes of configurable length, freezes the pipe on memory wait, and keeps stall and flush performance counters.

## Interface
- LU_STALL_CYCLES, default 1: bubbles inserted per load-use hazard; legal range 1..16.
- REDIRECT_PENALTY, default 1: cycles IF/ID is squashed per taken redirect; legal range 1..16.

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  IF stage presents a fetched instruction
- id_opcode  in  7  opcode of instruction in IF/ID
- id_rs1, id_rs2  in  5 each  source registers of instruction in IF/ID
- ex_valid  in  1  EX holds a real instruction
- ex_mem_read  in  1  EX instruction is a LOAD
- ex_rd  in  5  EX destination register
- branch_taken  in  1  EX resolves a taken branch or a JAL/JALR redirect
- mem_busy  in  1  data memory not ready; whole pipe must freeze
- pc_we  out  1  PC register update enable
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID; has priority over ifid_we
- idex_bubble  out  1  load NOP into ID/EX
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- id_valid  out  1  IF/ID holds a live instruction
- stall_cnt  out  32  cycles with pc_we=0
- flush_cnt  out  32  accepted redirects

## Operation
- Register usage is derived from the opcode:
  - uses_rs1 for OP, OP_IMM, JALR, LOAD, STORE and BRANCH.
  - uses_rs2 for OP, STORE and BRANCH.
  - LUI and JAL use neither.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- The FSM has three states: RUN, LU_STALL and FLUSH. A down-counter cnt (5 bits) tracks the remaining cycles of a stall or flush.
- Priority in every state: reset > mem_busy > branch_taken > load_use.
- mem_busy, any state:
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
  - State, cnt and id_valid hold.
- branch_taken, any state:
  - Outputs: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  - flush_cnt increments.
  - If REDIRECT_PENALTY>1, load cnt=REDIRECT_PENALTY-1 and go to FLUSH; otherwise go to RUN.
  - A redirect while in FLUSH restarts the counter.
- load_use in RUN:
  - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
  - If LU_STALL_CYCLES>1, load cnt=LU_STALL_CYCLES-1 and go to LU_STALL.
- RUN with no event: pc_we=1, ifid_we=1, all other controls 0.
- LU_STALL: same outputs as the load_use cycle, with load_use masked. cnt decrements each cycle; go to RUN on the edge where cnt goes 1→0.
- FLUSH: pc_we=1, ifid_we=1, ifid_flush=1. cnt decrements; go to RUN on 1→0.
- idex_bubble is also forced to 1 whenever id_valid=0, except under mem_busy.
- id_valid next value:
  - ifid_flush → 0
  - else ifid_we → if_valid
  - else hold.
- stall_cnt increments every non-reset cycle with pc_we=0. Both counters wrap at 2^32.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs, with zero-cycle latency to the pipeline registers. id_valid and the counters are registered.
- Load-use hazard: exactly LU_STALL_CYCLES cycles with pc_we=0. The detect cycle counts as the first of them.
- Redirect: exactly REDIRECT_PENALTY cycles with ifid_flush=1, plus any cycles stretched by mem_busy.
- mem_busy stretches the current state with no loss of count. A held branch_taken is acted on in the first cycle after mem_busy falls.
- Reset cycle:
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
  - Next state: RUN, cnt=0, id_valid=0, stall_cnt=0, flush_cnt=0.
- Reset mid-stall or mid-flush abandons the sequence immediately.

## Structure
- pipe_ctrl_pkg holds:
  - the opcode constants: OP, OP_IMM, JALR, LOAD, STORE, BRANCH, LUI, JAL;
  - ctrl_state_t (RUN, LU_STALL, FLUSH);
  - the functions uses_rs1(opcode) and uses_rs2(opcode).
- One sub-module, load_use_detect, is purely combinational and produces load_use. The FSM, counters and id_valid register live in pipe_hazard_ctrl.

## Test plan
- Load-use hazard, default parameters:
  - Stimulus: EX holds a LOAD with ex_rd=5; ID holds OP (opcode 0110011) with rs2=5.
  - Required: one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1; RUN on the next cycle.
- Register usage and x0 filtering:
  - LUI with instr[19:15]=5 against the same LOAD → no stall.
  - ex_rd=0 → no stall.
- LU_STALL_CYCLES=3: a hazard gives exactly 3 stall cycles. A 2-cycle mem_busy in the middle stretches the total to 5 cycles of pc_we=0, and pipe_hold=1 for 2 of them.
- REDIRECT_PENALTY=2 with redirects:
  - A single branch_taken gives ifid_flush=1 for 2 cycles, id_valid=0, flush_cnt=1.
  - A second branch_taken in the FLUSH cycle restarts the count, giving 2 more flush cycles and flush_cnt=2.
- Simultaneous events:
  - branch_taken and load_use together → flush wins; no pc_we=0 cycle.
  - mem_busy and branch_taken together → hold; flush in the first cycle after mem_busy drops.
- Reset asserted in cycle 2 of a 3-cycle LU_STALL: that cycle shows the reset output values; state returns to RUN, and id_valid and both counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control unit: opcodes, FSM state
// type and per-opcode source-register usage.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode inside {OP, OP_IMM, JALR, LOAD, STORE, BRANCH};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OP, STORE, BRANCH};
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: flags when the instruction in ID
// reads the (non-x0) destination of a LOAD currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1  = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
    hit_rs2  = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
    load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
               && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage RV32I core: load-use bubbles, redirect
// flushes, memory-wait freeze, and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES  = 1,
  parameter int unsigned REDIRECT_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        id_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [4:0] LU_RELOAD = 5'(LU_STALL_CYCLES - 1);
  localparam logic [4:0] RP_RELOAD = 5'(REDIRECT_PENALTY - 1);

  ctrl_state_t state;
  logic [4:0]  cnt;
  logic        load_use;

  load_use_detect u_detect (
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // Mealy control outputs; load_use is only consulted in RUN, which masks it
  // during an ongoing stall.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pipe_hold = 1'b1;
    end else begin
      if (branch_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        case (state)
          FLUSH: begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
          end
          LU_STALL: idex_bubble = 1'b1;
          default: begin
            if (load_use) begin
              idex_bubble = 1'b1;
            end else begin
              pc_we   = 1'b1;
              ifid_we = 1'b1;
            end
          end
        endcase
      end
      if (!id_valid) idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!mem_busy) begin
      if (branch_taken) begin
        if (REDIRECT_PENALTY > 1) begin
          state <= FLUSH;
          cnt   <= RP_RELOAD;
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end else begin
        case (state)
          FLUSH, LU_STALL: begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) state <= RUN;
          end
          default: begin
            if (load_use && (LU_STALL_CYCLES > 1)) begin
              state <= LU_STALL;
              cnt   <= LU_RELOAD;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ifid_flush)   id_valid <= 1'b0;
      else if (ifid_we) id_valid <= if_valid;
      if (!pc_we) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && !mem_busy) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule
